axi_rr_arb: RTL and testbench

AXI_RR_ARB -- requirements
Module: axi_rr_arb

---
 rtl/axi_rr_arb_pkg.sv | 27 ++
 rtl/axi_rr_arb_rr_pick.sv | 41 ++++
 rtl/axi_rr_arb.sv | 157 +++++++++++++++
 tb/tb_axi_rr_arb.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rr_arb_pkg.sv
// Shared definitions for the round-robin AXI-Stream packet arbiter.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package axi_rr_arb_pkg;

    // Arbiter FSM encoding: IDLE picks a winner, LOCKED streams its packet.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Beat counter width; wide enough for any MAX_BEATS up to 65535.
    localparam int BEAT_CNT_W = 16;

    // Ceiling log2, used to size the source-port index (tuser).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_rr_arb_rr_pick.sv
// Round-robin winner selection with an urgent-first override.
// Latency: purely combinational.
// Backpressure: none; result is only consumed when the arbiter is idle.
module rr_pick
    import axi_rr_arb_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int IDX_W     = clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] urgent,
    input  logic [IDX_W-1:0]     last_grant,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_valid
);

    logic [NUM_PORTS-1:0] urg_req;
    logic [NUM_PORTS-1:0] pool;
    logic [IDX_W-1:0]     cand;

    // Urgent requesters, when any exist, shadow all ordinary ones.
    assign urg_req = req & urgent;
    assign pool    = (|urg_req) ? urg_req : req;

    // Scan starting one past the last winner; NUM_PORTS is a power of two so
    // the index wraps naturally in IDX_W bits and the last candidate is
    // last_grant itself.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = last_grant + IDX_W'(i);
            if (!gnt_valid && pool[cand]) begin
                gnt_idx   = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_rr_arb.sv
// N:1 AXI-Stream packet arbiter, round-robin with urgent priority and forced release.
// Latency: 1 cycle input-to-output through a single output register; 1 idle cycle between grants.
// Backpressure: only the granted port sees tready, equal to ~m_axis_tvalid | m_axis_tready.
module axi_rr_arb
    import axi_rr_arb_pkg::*;
#(
    parameter int   DATA_WIDTH = 32,
    parameter int   NUM_PORTS  = 4,
    parameter int   MAX_BEATS  = 256,
    localparam int  USER_W     = clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            sync_reset,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    input  logic [NUM_PORTS-1:0]            urgent,
    output logic                            m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic [USER_W-1:0]               m_axis_tuser,
    input  logic                            m_axis_tready
);

    arb_state_e              state_q, state_d;
    logic [USER_W-1:0]       grant_q, grant_d;
    logic [USER_W-1:0]       last_grant_q, last_grant_d;
    logic [BEAT_CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic                    m_vld_q, m_vld_d;
    logic [DATA_WIDTH-1:0]   m_dat_q, m_dat_d;
    logic                    m_last_q, m_last_d;
    logic [USER_W-1:0]       m_user_q, m_user_d;

    logic [DATA_WIDTH-1:0]   in_dat [NUM_PORTS];
    logic [USER_W-1:0]       pick_idx;
    logic                    pick_vld;
    logic                    out_ready;
    logic                    acc;
    logic                    force_rel;
    logic                    rel;
    logic [NUM_PORTS-1:0]    s_rdy;

    // Unpack the flat data bus into per-port words.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign in_dat[p] = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (USER_W)
    ) u_pick (
        .req        (s_axis_tvalid),
        .urgent     (urgent),
        .last_grant (last_grant_q),
        .gnt_idx    (pick_idx),
        .gnt_valid  (pick_vld)
    );

    // Output slot can take a new beat when empty or being drained this cycle.
    assign out_ready = ~m_vld_q | m_axis_tready;
    assign acc       = (state_q == LOCKED) & s_axis_tvalid[grant_q] & out_ready;
    assign cnt_inc   = cnt_q + BEAT_CNT_W'(1);
    // Forced release fires on the beat that brings the count to MAX_BEATS.
    assign force_rel = (cnt_inc == BEAT_CNT_W'(MAX_BEATS));
    assign rel       = acc & (s_axis_tlast[grant_q] | force_rel);

    // FSM state register.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: grant only from IDLE, release only on the closing beat.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = LOCKED;
            LOCKED:  if (rel)      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: the granted port alone sees the output-slot readiness.
    always_comb begin
        s_rdy = '0;
        if (state_q == LOCKED) begin
            s_rdy[grant_q] = out_ready;
        end
    end

    assign s_axis_tready = s_rdy;

    // Grant bookkeeping: latch winner and clear count on grant, remember owner on release.
    always_comb begin
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        if (state_q == IDLE && pick_vld) begin
            grant_d = pick_idx;
            cnt_d   = '0;
        end
        if (acc) begin
            cnt_d = cnt_inc;
        end
        if (rel) begin
            last_grant_d = grant_q;
        end
    end

    // Output slot: load on accept, otherwise hold until the sink takes it.
    always_comb begin
        m_vld_d  = m_vld_q;
        m_dat_d  = m_dat_q;
        m_last_d = m_last_q;
        m_user_d = m_user_q;
        if (acc) begin
            m_vld_d  = 1'b1;
            m_dat_d  = in_dat[grant_q];
            m_last_d = s_axis_tlast[grant_q] | force_rel;
            m_user_d = grant_q;
        end else if (m_axis_tready) begin
            m_vld_d  = 1'b0;
        end
    end

    // Datapath and grant registers; reset points last_grant at the top port so
    // the first post-reset scan starts at port 0.
    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            grant_q      <= '0;
            last_grant_q <= USER_W'(NUM_PORTS - 1);
            cnt_q        <= '0;
            m_vld_q      <= 1'b0;
            m_dat_q      <= '0;
            m_last_q     <= 1'b0;
            m_user_q     <= '0;
        end else begin
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            m_vld_q      <= m_vld_d;
            m_dat_q      <= m_dat_d;
            m_last_q     <= m_last_d;
            m_user_q     <= m_user_d;
        end
    end

    assign m_axis_tvalid = m_vld_q;
    assign m_axis_tdata  = m_dat_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;

endmodule

// File: tb/tb_axi_rr_arb.sv
// Self-checking bench for axi_rr_arb against a transaction-level reference model.
// Latency: model predicts every cycle's tready and output slot contents.
// Backpressure: randomized source gaps, sink stalls and urgent requests.
module tb_axi_rr_arb;

    localparam int NP = 4;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int UW = 2;

    logic               clk;
    logic               sync_reset;
    logic [NP-1:0]      s_axis_tvalid;
    logic [NP*DW-1:0]   s_axis_tdata;
    logic [NP-1:0]      s_axis_tlast;
    logic [NP-1:0]      s_axis_tready;
    logic [NP-1:0]      urgent;
    logic               m_axis_tvalid;
    logic [DW-1:0]      m_axis_tdata;
    logic               m_axis_tlast;
    logic [UW-1:0]      m_axis_tuser;
    logic               m_axis_tready;

    axi_rr_arb #(
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .MAX_BEATS  (MB)
    ) dut (
        .clk           (clk),
        .sync_reset    (sync_reset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .urgent        (urgent),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Source packets per port: bit DW is tlast, low bits are data.
    logic [DW:0] src_q [NP][$];
    int          seq = 0;
    int          tot_pushed = 0;

    // Knobs
    int          vld_gap = 0;
    int          rdy_gap = 0;
    int          urg_pct = 0;
    logic [NP-1:0] urg_force = '0;
    bit          rdy_hold = 0;

    // Reference model: arbiter ownership and a one-deep output slot.
    bit          m_locked = 0;
    int          m_owner = 0;
    int          m_last_grant = NP - 1;
    int          m_cnt = 0;
    bit          slot_vld = 0;
    logic [DW-1:0] slot_dat = '0;
    bit          slot_last = 0;
    int          slot_user = 0;

    // Delivered beats, in order.
    int          log_user[$];
    bit          log_last[$];
    int          log_cyc[$];
    int          cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Next winner: urgent valid ports first, then round-robin from last+1.
    function automatic int model_pick(input logic [NP-1:0] vld, input logic [NP-1:0] urg, input int last);
        logic [NP-1:0] pool;
        pool = ((vld & urg) != '0) ? (vld & urg) : vld;
        for (int k = 1; k <= NP; k++) begin
            if (pool[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    function automatic bit busy();
        bit b;
        b = slot_vld || m_locked;
        for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) b = 1;
        return b;
    endfunction

    task automatic push_pkt(input int p, input int len, input bit with_last);
        logic [DW:0] b;
        for (int i = 0; i < len; i++) begin
            b[DW-1:0] = {8'(p), 24'(seq)};
            b[DW]     = with_last && (i == len - 1);
            seq++;
            src_q[p].push_back(b);
            tot_pushed++;
        end
    endtask

    task automatic clear_log();
        log_user.delete();
        log_last.delete();
        log_cyc.delete();
        tot_pushed = 0;
    endtask

    // One clock: drive inputs, check DUT against model, advance model across the next edge.
    task automatic step();
        logic [DW:0]   b;
        logic [NP-1:0] etr;
        bit            oready;
        int            g;
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            if (src_q[p].size() > 0 && $urandom_range(0, 99) >= vld_gap) begin
                s_axis_tvalid[p]           = 1'b1;
                s_axis_tdata[p*DW +: DW]   = src_q[p][0][DW-1:0];
                s_axis_tlast[p]            = src_q[p][0][DW];
            end else begin
                s_axis_tvalid[p]           = 1'b0;
                s_axis_tdata[p*DW +: DW]   = $urandom;
                s_axis_tlast[p]            = 1'($urandom_range(0, 1));
            end
            urgent[p] = urg_force[p] | ($urandom_range(0, 99) < urg_pct);
        end
        m_axis_tready = !rdy_hold && ($urandom_range(0, 99) >= rdy_gap);
        #1;
        oready = !slot_vld || m_axis_tready;
        etr = '0;
        if (m_locked && oready) etr[m_owner] = 1'b1;
        chk("s_tready", s_axis_tready, etr);
        chk("m_tvalid", m_axis_tvalid, slot_vld);
        if (slot_vld) begin
            chk("m_tdata", m_axis_tdata, slot_dat);
            chk("m_tlast", m_axis_tlast, slot_last);
            chk("m_tuser", m_axis_tuser, slot_user);
        end
        if (slot_vld && m_axis_tready) begin
            log_user.push_back(slot_user);
            log_last.push_back(slot_last);
            log_cyc.push_back(cyc);
            slot_vld = 0;
        end
        if (m_locked) begin
            if (s_axis_tvalid[m_owner] && oready) begin
                b = src_q[m_owner].pop_front();
                m_cnt++;
                slot_vld  = 1;
                slot_dat  = b[DW-1:0];
                slot_last = b[DW] || (m_cnt == MB);
                slot_user = m_owner;
                if (slot_last) begin
                    m_locked     = 0;
                    m_last_grant = m_owner;
                end
            end
        end else begin
            g = model_pick(s_axis_tvalid, urgent, m_last_grant);
            if (g >= 0) begin
                m_locked = 1;
                m_owner  = g;
                m_cnt    = 0;
            end
        end
        cyc++;
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        s_axis_tvalid = '0;
        urgent        = '0;
        m_axis_tready = 1'b1;
        sync_reset    = 1'b1;
        #1;
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_m_tdata",  m_axis_tdata,  0);
        chk("rst_m_tlast",  m_axis_tlast,  0);
        chk("rst_m_tuser",  m_axis_tuser,  0);
        chk("rst_s_tready", s_axis_tready, 0);
        m_locked     = 0;
        m_last_grant = NP - 1;
        m_cnt        = 0;
        slot_vld     = 0;
        @(negedge clk);
        sync_reset = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (busy() && n < limit) begin
            step();
            n++;
        end
        chk("drain_done", busy(), 0);
    endtask

    task automatic set_knobs(input int vg, input int rg, input int up, input logic [NP-1:0] uf);
        vld_gap   = vg;
        rdy_gap   = rg;
        urg_pct   = up;
        urg_force = uf;
        rdy_hold  = 0;
    endtask

    initial begin
        sync_reset    = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        urgent        = '0;
        m_axis_tready = 1'b0;

        // Four simultaneous 3-beat packets: order 0,1,2,3 with one idle cycle between.
        set_knobs(0, 0, 0, '0);
        do_reset();
        clear_log();
        for (int p = 0; p < NP; p++) push_pkt(p, 3, 1);
        drain(100);
        chk("s1_beats", log_user.size(), 12);
        if (log_user.size() == 12) begin
            for (int i = 0; i < 12; i++) chk("s1_order", log_user[i], i / 3);
            for (int k = 1; k < 4; k++) chk("s1_gap", log_cyc[3*k] - log_cyc[3*k-1], 2);
        end

        // Urgent port 2 wins over earlier ports, then round-robin resumes.
        set_knobs(0, 0, 0, 4'b0100);
        do_reset();
        clear_log();
        push_pkt(0, 2, 1);
        push_pkt(1, 2, 1);
        push_pkt(2, 2, 1);
        drain(100);
        chk("s2_beats", log_user.size(), 6);
        if (log_user.size() == 6) begin
            chk("s2_first",  log_user[0], 2);
            chk("s2_second", log_user[2], 0);
            chk("s2_third",  log_user[4], 1);
        end

        // Six beats without tlast: forced release after beat 4, rest under a new grant.
        set_knobs(0, 0, 0, '0);
        do_reset();
        clear_log();
        push_pkt(1, 5, 0);
        push_pkt(1, 1, 1);
        drain(100);
        chk("s3_beats", log_user.size(), 6);
        if (log_user.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("s3_last", log_last[i], (i == 3 || i == 5));
                chk("s3_user", log_user[i], 1);
            end
            chk("s3_regrant_gap", log_cyc[4] - log_cyc[3], 2);
        end

        // Sink stalls five cycles mid-packet: slot holds, granted tready drops.
        set_knobs(0, 0, 0, '0);
        do_reset();
        clear_log();
        push_pkt(0, 4, 1);
        repeat (3) step();
        rdy_hold = 1;
        repeat (5) begin
            step();
            chk("s4_hold_tready", s_axis_tready, 0);
        end
        rdy_hold = 0;
        drain(100);
        chk("s4_beats", log_user.size(), 4);
        if (log_user.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("s4_last", log_last[i], i == 3);
        end

        // Reset at beat 2 of a 5-beat packet; port 0 still wins first afterwards.
        set_knobs(0, 0, 0, '0);
        do_reset();
        clear_log();
        push_pkt(0, 5, 1);
        push_pkt(2, 2, 1);
        for (int n = 0; n < 20 && !(m_locked && m_cnt == 2); n++) step();
        do_reset();
        clear_log();
        drain(100);
        chk("s5_beats", log_user.size(), 5);
        if (log_user.size() > 0) chk("s5_first_after_rst", log_user[0], 0);

        // Lone requester with single-beat packets: outputs every other cycle.
        set_knobs(0, 0, 0, '0);
        do_reset();
        clear_log();
        for (int i = 0; i < 3; i++) push_pkt(3, 1, 1);
        drain(100);
        chk("s6_beats", log_user.size(), 3);
        if (log_user.size() == 3) begin
            chk("s6_gap1", log_cyc[1] - log_cyc[0], 2);
            chk("s6_gap2", log_cyc[2] - log_cyc[1], 2);
        end

        // Randomized traffic with gaps, stalls and urgent requests.
        set_knobs(20, 25, 15, '0);
        do_reset();
        clear_log();
        for (int n = 0; n < 800; n++) begin
            for (int p = 0; p < NP; p++) begin
                if (src_q[p].size() < 2 && $urandom_range(0, 7) == 0) begin
                    push_pkt(p, $urandom_range(1, 6), $urandom_range(0, 7) != 0);
                end
            end
            step();
        end
        for (int p = 0; p < NP; p++) push_pkt(p, 1, 1);
        drain(3000);
        chk("rnd_beats", log_user.size(), tot_pushed);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1);
    end

endmodule
